// File: rtl/wb_slave_mem_responder_if.sv
// wb_slave_mem_responder_if: Wishbone B3 bus between the MAC DMA master and the memory slave.
interface wb_slave_mem_responder_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_slave_mem_responder.sv
// wb_slave_mem_responder: Wishbone B3 slave memory with wait states, error response and beat counter.
// Define WB_SLV_BURST_EN to add incrementing linear bursts (cti 010, bte 00).
module wb_slave_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    wb_slave_mem_responder_if.slave        bus,
    output logic [15:0]                    acc_count
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;
    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic          r_we;
    logic [3:0]    r_sel;
    logic [31:0]   r_dat;
    logic          r_burst;
    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_dat_o;
    logic [15:0]   r_acc;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_req;
    logic          w_valid;
    logic          w_burst;
    logic          w_wr_en;
    logic [31:0]   w_wr_dat;
    logic [3:0]    w_wr_sel;
    logic [15:0]   w_acc_inc;
    assign w_off     = bus.wb_adr_i - BASE_ADDR;
    assign w_idx     = w_off[AW+1:2];
    assign w_req     = bus.wb_cyc_i & bus.wb_stb_i;
    assign w_valid   = bus.wb_adr_i[1:0] == 2'b00 && w_off < 32'(DEPTH_WORDS * 4);
    assign w_acc_inc = r_acc + {15'd0, r_acc != 16'hFFFF};
`ifdef WB_SLV_BURST_EN
    assign w_burst = bus.wb_cti_i == 3'b010 && bus.wb_bte_i == 2'b00;
`else
    logic w_unused;
    assign w_unused = ^{bus.wb_cti_i, bus.wb_bte_i};
    assign w_burst  = 1'b0;
`endif
    // Burst beats carry fresh data each cycle, so they write from the live bus at the beat's closing edge.
    assign w_wr_en  = r_state == ACK && r_ack && r_we && (!r_burst || w_req) && !rst;
    assign w_wr_dat = r_burst ? bus.wb_dat_i : r_dat;
    assign w_wr_sel = r_burst ? bus.wb_sel_i : r_sel;
    always_ff @(posedge clk)
        if (w_wr_en)
            for (int i = 0; i < 4; i++)
                if (w_wr_sel[i]) r_mem[r_idx][8*i +: 8] <= w_wr_dat[8*i +: 8];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_burst <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_o <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_idx   <= w_idx;
                    r_we    <= bus.wb_we_i;
                    r_sel   <= bus.wb_sel_i;
                    r_dat   <= bus.wb_dat_i;
                    r_burst <= w_burst;
                    r_cnt   <= 4'(WAIT_STATES - 1);
                    if (!w_valid) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        if (!bus.wb_we_i) r_dat_o <= r_mem[w_idx];
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: if (!bus.wb_cyc_i) begin
                    r_state <= IDLE;
                end else if (r_cnt == 4'd0) begin
                    r_state <= ACK;
                    r_ack   <= 1'b1;
                    if (!r_we) r_dat_o <= r_mem[r_idx];
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                ACK: if (!r_burst) begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_acc   <= w_acc_inc;
                end else if (!bus.wb_cyc_i) begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end else if (!bus.wb_stb_i) begin
                    r_ack <= 1'b0;
                end else if (!r_ack) begin
                    r_ack <= 1'b1;
                end else begin
                    r_acc <= w_acc_inc;
                    if (bus.wb_cti_i != 3'b010) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b0;
                    end else if (&r_idx) begin
                        r_state <= ERR;
                        r_ack   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        if (!r_we) r_dat_o <= r_mem[r_idx + 1'b1];
                    end
                end
                ERR: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end
    assign bus.wb_ack_o = r_ack;
    assign bus.wb_err_o = r_err;
    assign bus.wb_dat_o = r_dat_o;
    assign acc_count    = r_acc;
endmodule

// File: tb/tb_wb_slave_mem_responder.sv
// tb_wb_slave_mem_responder: table vectors, random accesses against a transaction model, and corner sequences.
module tb_wb_slave_mem_responder;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    wb_slave_mem_responder_if bus1 ();
    wb_slave_mem_responder_if bus3 ();
    logic [15:0] acc1, acc3;
    wb_slave_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .acc_count(acc1));
    wb_slave_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave), .acc_count(acc3));
    int          dsel = 0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    assign bus1.wb_adr_i = adr;
    assign bus1.wb_dat_i = dat;
    assign bus1.wb_sel_i = sel;
    assign bus1.wb_we_i  = we;
    assign bus1.wb_cti_i = cti;
    assign bus1.wb_bte_i = bte;
    assign bus1.wb_cyc_i = cyc && dsel == 0;
    assign bus1.wb_stb_i = stb && dsel == 0;
    assign bus3.wb_adr_i = adr;
    assign bus3.wb_dat_i = dat;
    assign bus3.wb_sel_i = sel;
    assign bus3.wb_we_i  = we;
    assign bus3.wb_cti_i = cti;
    assign bus3.wb_bte_i = bte;
    assign bus3.wb_cyc_i = cyc && dsel == 1;
    assign bus3.wb_stb_i = stb && dsel == 1;
    logic        ack, err;
    logic [31:0] dat_o;
    logic [15:0] acc;
    assign ack   = dsel == 1 ? bus3.wb_ack_o : bus1.wb_ack_o;
    assign err   = dsel == 1 ? bus3.wb_err_o : bus1.wb_err_o;
    assign dat_o = dsel == 1 ? bus3.wb_dat_o : bus1.wb_dat_o;
    assign acc   = dsel == 1 ? acc3 : acc1;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] mdl [2][DEPTH];
    int          macc [2] = '{0, 0};
    int          ws [2] = '{1, 3};
    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  s;
        logic        e;
        logic [31:0] rd;
        int          acc;
    } vec_t;
    vec_t vt [10];
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    function automatic bit addr_ok(input logic [31:0] a);
        return a % 4 == 0 && longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + DEPTH * 4;
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction
    // Called #1 after a rising edge; returns #1 after the edge that follows the ack/err cycle.
    task automatic access(input int d, input logic [31:0] a, input logic w, input logic [31:0] dt,
                          input logic [3:0] s, output logic ok, output logic er, output int lat,
                          output logic [31:0] rd);
        dsel = d; adr = a; we = w; dat = dt; sel = s; cti = '0; bte = '0; cyc = 1'b1; stb = 1'b1;
        ok = 1'b0; er = 1'b0; lat = 0; rd = '0;
        for (int k = 1; k <= 24 && !ok && !er; k++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                ok = ack; er = err; lat = k; rd = dat_o;
                chk("ack_err_exclusive", 32'(ack & err), 0);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("single_cycle_term", 32'({ack, err}), 0);
    endtask
    task automatic op(input int d, input logic [31:0] a, input logic w, input logic [31:0] dt,
                      input logic [3:0] s, input string tag);
        logic ok, er;
        int lat, idx;
        logic [31:0] rd;
        bit v;
        v = addr_ok(a);
        idx = int'((a - BASE) >> 2);
        access(d, a, w, dt, s, ok, er, lat, rd);
        chk({tag, "_err"}, 32'(er), 32'(!v));
        chk({tag, "_ack"}, 32'(ok), 32'(v));
        chk({tag, "_lat"}, lat, v ? 1 + ws[d] : 1);
        if (v && !w) chk({tag, "_rdata"}, rd, mdl[d][idx]);
        if (v && w) mdl[d][idx] = merge(mdl[d][idx], dt, s);
        if (v && macc[d] < 65535) macc[d]++;
        chk({tag, "_acc"}, 32'(acc), macc[d]);
    endtask
    initial begin
        logic ok, er;
        int lat;
        logic [31:0] rd, a;
        bit seen;
        vt[0] = '{BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1};
        vt[1] = '{BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 2};
        vt[2] = '{BASE + 32'h20, 1'b1, 32'h11223344, 4'hF, 1'b0, 32'h0, 3};
        vt[3] = '{BASE + 32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 4};
        vt[4] = '{BASE + 32'h20, 1'b0, 32'h0, 4'hF, 1'b0, 32'h11BB33DD, 5};
        vt[5] = '{BASE + DEPTH * 4, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, 5};
        vt[6] = '{BASE + 32'h2, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, 5};
        vt[7] = '{BASE - 32'h4, 1'b1, 32'h1, 4'hF, 1'b1, 32'h0, 5};
        vt[8] = '{BASE + (DEPTH - 1) * 4, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 6};
        vt[9] = '{BASE + (DEPTH - 1) * 4, 1'b0, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 7};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", 32'(bus1.wb_ack_o), 0);
        chk("reset_err", 32'(bus1.wb_err_o), 0);
        chk("reset_dat", bus1.wb_dat_o, 0);
        chk("reset_acc", 32'(acc1), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        foreach (vt[i]) begin
            access(0, vt[i].a, vt[i].w, vt[i].d, vt[i].s, ok, er, lat, rd);
            chk("vec_err", 32'(er), 32'(vt[i].e));
            chk("vec_ack", 32'(ok), 32'(!vt[i].e));
            chk("vec_lat", lat, vt[i].e ? 1 : 2);
            if (!vt[i].w && !vt[i].e) chk("vec_rdata", rd, vt[i].rd);
            chk("vec_acc", 32'(acc1), vt[i].acc);
        end
        macc[0] = 7;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) op(d, BASE + 4 * i, 1'b1, $urandom, 4'hF, "init");
        for (int n = 0; n < 100; n++) begin
            case ($urandom_range(0, 9))
                0: a = BASE + DEPTH * 4 + 4 * $urandom_range(0, 15);
                1: a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
                2: a = BASE - 4 * $urandom_range(1, 16);
                default: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
            endcase
            op(n < 80 ? 0 : 1, a, 1'(($urandom & 1)), $urandom, 4'($urandom), "rand");
        end
        // Held strobe must leave an idle gap between acks.
        dsel = 0; adr = BASE + 20; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk("held_ack", 32'(ack), 32'(k % (2 + ws[0]) == 1 + ws[0]));
            if (ack) chk("held_rdata", dat_o, mdl[0][5]);
        end
        cyc = 1'b0; stb = 1'b0;
        macc[0] += 2;
        @(posedge clk); #1;
        chk("held_acc", 32'(acc1), macc[0]);
        dsel = 1; adr = BASE + 28; we = 1'b1; dat = 32'h5; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            seen |= ack | err;
        end
        chk("drop_no_ack", 32'(seen), 0);
        op(1, BASE + 28, 1'b0, 32'h0, 4'hF, "drop_read");
`ifdef WB_SLV_BURST_EN
        dsel = 0; adr = BASE; we = 1'b1; sel = 4'hF; cti = 3'b010; bte = 2'b00; dat = 32'hB0B0_0000;
        cyc = 1'b1; stb = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (ack) lat = k;
        end
        chk("burst_first_lat", lat, 2);
        for (int b = 1; b < 4; b++) begin
            @(posedge clk); #1;
            chk("burst_ack", 32'(ack), 1);
            adr = BASE + 4 * b; dat = 32'hB0B0_0000 + b; cti = b == 3 ? 3'b111 : 3'b010;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; cti = '0;
        chk("burst_end_ack", 32'(ack), 0);
        for (int b = 0; b < 4; b++) mdl[0][b] = 32'hB0B0_0000 + b;
        macc[0] += 4;
        chk("burst_acc", 32'(acc1), macc[0]);
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) op(0, BASE + 4 * b, 1'b0, 32'h0, 4'hF, "burst_read");
`endif
        dsel = 1; adr = BASE + 36; we = 1'b1; dat = 32'h77; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_ack", 32'({bus1.wb_ack_o, bus3.wb_ack_o}), 0);
        chk("rst_err", 32'({bus1.wb_err_o, bus3.wb_err_o}), 0);
        chk("rst_dat1", bus1.wb_dat_o, 0);
        chk("rst_dat3", bus3.wb_dat_o, 0);
        chk("rst_acc", 32'({acc1, acc3}), 0);
        cyc = 1'b0; stb = 1'b0;
        #1;
        rst = 1'b0;
        macc[0] = 0; macc[1] = 0;
        @(posedge clk); #1;
        op(1, BASE + 36, 1'b0, 32'h0, 4'hF, "rst_read");
        op(0, BASE + 20, 1'b0, 32'h0, 4'hF, "rst_read1");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
